// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- multi-cycle multiply/divide unit for the EX stage.
//
// Owns the HI/LO register pair. Executes mult, multu, div, divu (multi-cycle,
// latency modelled by a down-counter) and mthi, mtlo (single cycle). While a
// mult/div is in flight, busy is high so the hazard unit can stall the pipe.
// The result is computed from operands latched at issue. HI/LO are written on
// the edge where the counter reaches zero.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   start    in   issue strobe for op
//   op       in   [2:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                 6 mtlo, 7 reserved
//   rs_val   in   [WIDTH-1:0] operand A (multiplicand / dividend / mt* source)
//   rt_val   in   [WIDTH-1:0] operand B (multiplier / divisor)
//   cancel   in   abort the in-flight operation (exception flush)
//   rd_sel   in   read select: 0 HI, 1 LO
//   rd_data  out  [WIDTH-1:0] rd_sel ? LO : HI
//   busy     out  high while a mult/div is in flight
//   hi       out  [WIDTH-1:0] current HI
//   lo       out  [WIDTH-1:0] current LO
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             cancel,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    // Architectural and in-flight state
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // -----------------------------------------------------------------------
    // Arithmetic on the latched operands
    // -----------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               b_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   div_b_s;
    logic [WIDTH-1:0]   div_b_u;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   quo_u, rem_u;

    // A signed product modulo 2^(2*WIDTH) equals the unsigned product of the
    // sign-extended operands, so both flavours share one multiplier form.
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    assign b_zero  = (b_q == '0);
    assign div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

    // Substituting a divisor of 1 keeps the divider defined for x/0 (whose
    // result is discarded) and makes MIN/-1 yield quotient MIN, remainder 0.
    assign div_b_s = (b_zero || div_ovf) ? WIDTH'(1) : b_q;
    assign div_b_u = b_zero ? WIDTH'(1) : b_q;

    assign quo_s = $signed(a_q) / $signed(div_b_s);
    assign rem_s = $signed(a_q) % $signed(div_b_s);
    assign quo_u = a_q / div_b_u;
    assign rem_u = a_q % div_b_u;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;

        if (busy_q) begin
            if (cancel) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_d = 1'b0;
                    unique case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (!b_zero) begin
                                lo_d = quo_s;
                                hi_d = rem_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!b_zero) begin
                                lo_d = quo_u;
                                hi_d = rem_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end else if (start && !cancel) begin
            unique case (op)
                OP_MULT, OP_MULTU: begin
                    op_d   = op_e'(op);
                    a_d    = rs_val;
                    b_d    = rt_val;
                    cnt_d  = CW'(MULT_CYCLES);
                    busy_d = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    op_d   = op_e'(op);
                    a_d    = rs_val;
                    b_d    = rt_val;
                    cnt_d  = CW'(DIV_CYCLES);
                    busy_d = 1'b1;
                end
                OP_MTHI: hi_d = rs_val;
                OP_MTLO: lo_d = rs_val;
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values regardless of statement order.
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= OP_NONE;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = busy_q;
    assign rd_data = rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int W      = 32;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         cancel;
    logic         rd_sel;
    logic [W-1:0] rd_data;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t sb_q[$];
    res_t model;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .cancel (cancel),
        .rd_sel (rd_sel),
        .rd_data(rd_data),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic in 64-bit integers, independent of the RTL form.
    function automatic res_t ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input res_t cur);
        res_t            r;
        longint          ps, sa, sb, q, m;
        longint unsigned pu;
        r = cur;
        case (o)
            OP_MULT: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                r.hi = ps[63:32];
                r.lo = ps[31:0];
            end
            OP_MULTU: begin
                pu = {32'b0, a} * {32'b0, b};
                r.hi = pu[63:32];
                r.lo = pu[31:0];
            end
            OP_DIV: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                m  = sa % sb;
                r.lo = q[31:0];
                r.hi = m[31:0];
            end
            OP_DIVU: if (b != 0) begin
                r.lo = a / b;
                r.hi = a % b;
            end
            default: ;
        endcase
        return r;
    endfunction

    // Present a start for one edge; mult/div expectations go to the scoreboard.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start = 1'b0;
        case (o)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                model = ref_result(o, a, b, model);
                sb_q.push_back(model);
            end
            OP_MTHI: model.hi = a;
            OP_MTLO: model.lo = a;
            default: ;
        endcase
    endtask

    // Count busy cycles after acceptance (bounded), then pop and compare.
    task automatic wait_done(input string tag, input int n);
        int   cyc;
        res_t e;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_busy_len"}, W'(cyc), W'(n));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, W'(0), W'(1));
        end else begin
            e = sb_q.pop_front();
            check({tag, "_hi"}, hi, e.hi);
            check({tag, "_lo"}, lo, e.lo);
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b1;
        op     = OP_MULT;
        rs_val = 32'h0000_0003;
        rt_val = 32'h0000_0004;
        cancel = 1'b0;
        rd_sel = 1'b0;
        model  = '0;

        // 1. Reset dominates a pending start
        tick();
        tick();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", W'(busy), W'(0));
        start = 1'b0;
        reset = 1'b1;
        tick();

        issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done("mult", MULT_N);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFFE);
        rd_sel = 1'b1;
        #1;
        check("rd_lo", rd_data, 32'hFFFF_FFFE);
        rd_sel = 1'b0;
        #1;
        check("rd_hi", rd_data, 32'hFFFF_FFFF);
        tick();

        // 2. multu; a different op held on start throughout busy is ignored
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start  = 1'b1;
        op     = OP_MULT;
        rs_val = 32'h0000_0005;
        rt_val = 32'h0000_0007;
        wait_done("multu", MULT_N);
        start = 1'b0;
        check("multu_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_lo_const", lo, 32'h0000_0001);
        tick();
        check("multu_no_reissue", W'(busy), W'(0));

        // 3. Signed divide, then divide by zero leaves HI/LO untouched
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done("div", DIV_N);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'h0000_0007, 32'h0000_0000);
        wait_done("divu_zero", DIV_N);
        check("divu_zero_hi", hi, 32'hFFFF_FFFF);
        check("divu_zero_lo", lo, 32'hFFFF_FFFD);
        issue(OP_DIVU, 32'h0000_0064, 32'h0000_0007);
        wait_done("divu", DIV_N);

        // 4. Most-negative / -1
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", DIV_N);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        // 5. mthi / mtlo back to back, busy never raised
        issue(OP_MTHI, 32'h0000_1234, 32'h0);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_busy", W'(busy), W'(0));
        issue(OP_MTLO, 32'h0000_5678, 32'h0);
        check("mtlo_lo", lo, 32'h0000_5678);
        check("mtlo_hi", hi, 32'h0000_1234);
        check("mtlo_busy", W'(busy), W'(0));

        // cancel while idle blocks a start and has no other effect
        cancel = 1'b1;
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        cancel = 1'b0;
        model.hi = 32'h0000_1234;
        check("cancel_idle_hi", hi, 32'h0000_1234);

        // mult 3x4 cancelled on its 3rd busy cycle
        start  = 1'b1;
        op     = OP_MULT;
        rs_val = 32'h3;
        rt_val = 32'h4;
        tick();
        start = 1'b0;
        check("cancel_busy1", W'(busy), W'(1));
        tick();
        tick();
        check("cancel_busy3", W'(busy), W'(1));
        cancel = 1'b1;
        start  = 1'b1;
        op     = OP_MTLO;
        rs_val = 32'hAAAA_AAAA;
        tick();
        cancel = 1'b0;
        start  = 1'b0;
        check("cancel_busy_drop", W'(busy), W'(0));
        repeat (MULT_N + 2) tick();
        check("cancel_hi", hi, model.hi);
        check("cancel_lo", lo, model.lo);
        check("cancel_no_busy", W'(busy), W'(0));

        // 6. Reset on the 4th busy cycle of a divide
        start  = 1'b1;
        op     = OP_DIV;
        rs_val = 32'h0000_0064;
        rt_val = 32'h0000_0003;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("rst_mid_busy4", W'(busy), W'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model = '0;
        check("rst_mid_busy", W'(busy), W'(0));
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        repeat (DIV_N + 2) tick();
        check("rst_mid_late_hi", hi, 32'h0);
        check("rst_mid_late_lo", lo, 32'h0);
        check("rst_mid_late_busy", W'(busy), W'(0));
        check("sb_drained", W'(sb_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
